// File: rtl/sram_access_arbiter.sv
// sram_access_arbiter: round-robin arbiter sharing one async SRAM between a writer and a reader
// Every output comes from a flop; wait states, write recovery and stale-request suppression live here.
module sram_access_arbiter #(
  parameter int ACCESS_CYC = 2,
  parameter int ADDR_W     = 20,
  parameter int DATA_W     = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_wr_req,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              o_wr_ack,
  input  logic              i_rd_req,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_rd_ack,
  output logic              o_busy,
  output logic [ADDR_W-1:0] o_sram_addr,
  output logic [DATA_W-1:0] o_sram_dq,
  output logic              o_sram_dq_oe,
  input  logic [DATA_W-1:0] i_sram_dq,
  output logic              o_sram_we_n,
  output logic              o_sram_oe_n,
  output logic              o_sram_ce_n,
  output logic              o_sram_lb_n,
  output logic              o_sram_ub_n
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_WREC  = 2'd2;
  localparam logic [1:0] S_READ  = 2'd3;
  localparam logic [3:0] CNT_INIT = 4'(ACCESS_CYC - 1);
  logic [1:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              last_w_q, last_w_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] dq_q, dq_d, rd_q, rd_d;
  logic              we_n_q, we_n_d, oe_n_q, oe_n_d, sel_n_q, sel_n_d, dq_oe_q, dq_oe_d;
  logic              wr_ack_q, wr_ack_d, rd_ack_q, rd_ack_d, busy_q;
  logic              wr_ok, rd_ok, gnt_w, gnt_r;
  // a port whose ack is showing this cycle still has its old request up
  assign wr_ok = i_wr_req & ~wr_ack_q;
  assign rd_ok = i_rd_req & ~rd_ack_q;
  assign gnt_w = wr_ok & (~rd_ok | ~last_w_q);
  assign gnt_r = rd_ok & ~gnt_w;
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    last_w_d = last_w_q;
    addr_d   = addr_q;
    dq_d     = dq_q;
    rd_d     = rd_q;
    we_n_d   = we_n_q;
    oe_n_d   = oe_n_q;
    sel_n_d  = sel_n_q;
    dq_oe_d  = dq_oe_q;
    wr_ack_d = 1'b0;
    rd_ack_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (gnt_w | gnt_r) begin
          state_d  = gnt_w ? S_WRITE : S_READ;
          cnt_d    = CNT_INIT;
          last_w_d = gnt_w;
          addr_d   = gnt_w ? i_wr_addr : i_rd_addr;
          dq_d     = gnt_w ? i_wr_data : dq_q;
          we_n_d   = ~gnt_w;
          oe_n_d   = gnt_w;
          sel_n_d  = 1'b0;
          dq_oe_d  = gnt_w;
        end
      end
      S_WRITE: begin
        state_d  = (cnt_q == 4'd0) ? S_WREC : S_WRITE;
        cnt_d    = (cnt_q == 4'd0) ? cnt_q : cnt_q - 4'd1;
        we_n_d   = (cnt_q == 4'd0);
        wr_ack_d = (cnt_q == 4'd0);
      end
      S_WREC: begin
        state_d = S_IDLE;
        sel_n_d = 1'b1;
        dq_oe_d = 1'b0;
      end
      default: begin
        state_d  = (cnt_q == 4'd0) ? S_IDLE : S_READ;
        cnt_d    = (cnt_q == 4'd0) ? cnt_q : cnt_q - 4'd1;
        rd_d     = (cnt_q == 4'd0) ? i_sram_dq : rd_q;
        rd_ack_d = (cnt_q == 4'd0);
        oe_n_d   = (cnt_q == 4'd0);
        sel_n_d  = (cnt_q == 4'd0);
      end
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      last_w_q <= 1'b0;
      addr_q   <= '0;
      dq_q     <= '0;
      rd_q     <= '0;
      we_n_q   <= 1'b1;
      oe_n_q   <= 1'b1;
      sel_n_q  <= 1'b1;
      dq_oe_q  <= 1'b0;
      wr_ack_q <= 1'b0;
      rd_ack_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_w_q <= last_w_d;
      addr_q   <= addr_d;
      dq_q     <= dq_d;
      rd_q     <= rd_d;
      we_n_q   <= we_n_d;
      oe_n_q   <= oe_n_d;
      sel_n_q  <= sel_n_d;
      dq_oe_q  <= dq_oe_d;
      wr_ack_q <= wr_ack_d;
      rd_ack_q <= rd_ack_d;
      busy_q   <= state_d != S_IDLE;
    end
  end
  assign o_wr_ack     = wr_ack_q;
  assign o_rd_ack     = rd_ack_q;
  assign o_rd_data    = rd_q;
  assign o_busy       = busy_q;
  assign o_sram_addr  = addr_q;
  assign o_sram_dq    = dq_q;
  assign o_sram_dq_oe = dq_oe_q;
  assign o_sram_we_n  = we_n_q;
  assign o_sram_oe_n  = oe_n_q;
  assign o_sram_ce_n  = sel_n_q;
  assign o_sram_lb_n  = sel_n_q;
  assign o_sram_ub_n  = sel_n_q;
endmodule

// File: doc/sram_access_arbiter.md
Name: sram_access_arbiter

Overview:
- Single-port arbiter for the external 1M x 16 SRAM, shared between the audio recorder (write requester) and the DSP/player (read requester).
- Replaces the combinational state-based muxing of SRAM address, DQ and WE_N in the top level.
- Sequences each access with programmable wait states, a write turnaround cycle, and round-robin fairness.
- Sits between the requesters and the SRAM pins. The top level ties o_sram_dq onto the inout DQ bus when o_sram_dq_oe is high.

Parameters:
- ACCESS_CYC, 2, cycles WE_N/OE_N held low per access; legal range 1..15.
- ADDR_W, 20, SRAM address width.
- DATA_W, 16, SRAM data width.

Ports:
- i_clk  in  1  system clock
- i_rst_n  in  1  asynchronous active-low reset
- i_wr_req  in  1  write request; held high until o_wr_ack
- i_wr_addr  in  ADDR_W  write address; stable while i_wr_req is high
- i_wr_data  in  DATA_W  write data; stable while i_wr_req is high
- o_wr_ack  out  1  one-cycle pulse: write completed
- i_rd_req  in  1  read request; held high until o_rd_ack
- i_rd_addr  in  ADDR_W  read address; stable while i_rd_req is high
- o_rd_data  out  DATA_W  captured read data; valid from o_rd_ack until the next read completes
- o_rd_ack  out  1  one-cycle pulse: o_rd_data updated
- o_busy  out  1  high when state is not S_IDLE
- o_sram_addr  out  ADDR_W  SRAM address
- o_sram_dq  out  DATA_W  SRAM write data
- o_sram_dq_oe  out  1  drive enable for DQ
- i_sram_dq  in  DATA_W  SRAM read data
- o_sram_we_n, o_sram_oe_n, o_sram_ce_n, o_sram_lb_n, o_sram_ub_n  out  1 each  SRAM strobes, active low

Behaviour:
- Clock and reset: one clock domain, i_clk. Reset is asynchronous, active-low (i_rst_n).
- All outputs are registered.
- Reset values:
  - state = S_IDLE
  - o_sram_addr = 0, o_sram_dq = 0, o_rd_data = 0
  - all strobes = 1 (inactive), o_sram_dq_oe = 0
  - o_wr_ack = 0, o_rd_ack = 0, o_busy = 0
  - last_grant = READ, wait counter = 0
- FSM states: S_IDLE, S_WRITE, S_WREC, S_READ.
- S_IDLE:
  - Evaluates eligible requests each edge. A port is ineligible in the cycle its own ack is high (stale-request suppression).
  - Only write eligible: grant write. Only read eligible: grant read.
  - Both eligible: grant the port that is not last_grant (round-robin). After reset, write wins the first tie.
  - On grant: latch addr (and data for a write) into the SRAM output registers, update last_grant, load counter = ACCESS_CYC-1.
- S_WRITE:
  - ce_n = lb_n = ub_n = 0, we_n = 0, oe_n = 1, dq_oe = 1.
  - Counter decrements each cycle. At counter == 0 → S_WREC.
  - Duration: exactly ACCESS_CYC cycles.
- S_WREC (one cycle):
  - we_n = 1; dq_oe stays 1 and address/data are held (hold time); ce_n stays 0; o_wr_ack = 1.
  - Next state is S_IDLE; dq_oe drops to 0 on entry to S_IDLE.
- S_READ:
  - ce_n = lb_n = ub_n = 0, oe_n = 0, we_n = 1, dq_oe = 0.
  - At counter == 0, on that edge: o_rd_data <= i_sram_dq, o_rd_ack <= 1, strobes deassert, → S_IDLE.
- Latency, measured from the grant edge E0:
  - Write: o_wr_ack is high in the cycle after edge E0+ACCESS_CYC.
  - Read: o_rd_ack is high in the cycle after edge E0+ACCESS_CYC.
  - Minimum spacing between grants is ACCESS_CYC+2 cycles for a write and ACCESS_CYC+1 for a read.
- Request sampling: requests are sampled only in S_IDLE. A granted access always completes, even if its req drops mid-access.
- Protocol violations:
  - A req dropped before ack while still ungranted is simply not served.
  - Addr/data changes after grant have no effect.
- Read/write isolation: o_sram_dq_oe and o_sram_oe_n are never both active in the same cycle.
- Address range: no wrap or range checking; the full 2^ADDR_W space is passed through.
- Reset mid-access: all strobes go inactive and dq_oe = 0 immediately (asynchronously). No ack is issued for the aborted access.
- ACCESS_CYC = 1 is legal: one strobe cycle per access.

Test Plan:
- ACCESS_CYC=2, write req addr=0x00010 data=0xBEEF → we_n low exactly 2 cycles, dq_oe high 3 cycles, o_wr_ack single pulse 3 cycles after grant edge, SRAM model holds 0xBEEF at 0x00010.
- Read req addr=0x00010 after that write → oe_n low 2 cycles, o_rd_data=0xBEEF with single-cycle o_rd_ack, we_n stays 1 throughout.
- Both reqs asserted together right after reset, held continuously → grant order W,R,W,R…; no port waits longer than one opposing access; dq_oe and oe_n never overlap.
- Requester drops req exactly one cycle after its ack (stale req present during the ack cycle) → no duplicate access: one write yields exactly one we_n pulse.
- i_rst_n pulled low in the 2nd S_WRITE cycle → we_n=1, ce_n=1, dq_oe=0 asynchronously; no o_wr_ack; after release, a fresh write completes normally.
- ACCESS_CYC=1, address 0xFFFFF write then read of 0xA5A5 → one-cycle strobes, correct data, o_sram_addr=0xFFFFF with no wrap.
